// File: rtl/misc_exec_pkg.sv
// Shared opcode/state encodings for the misc execution unit and its TX FIFO.
package misc_exec_pkg;

  typedef enum logic [5:0] {
    OP_NOP   = 6'd4,
    OP_HALT  = 6'd5,
    OP_IN    = 6'd6,
    OP_OUT   = 6'd7,
    OP_INW   = 6'd8,
    OP_OUTW  = 6'd9,
    OP_RDCYC = 6'd10
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_TX_PUSH,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  localparam logic [63:0] ALL_ONES = '1;

endpackage

// File: rtl/misc_exec_unit_tx_fifo.sv
// Byte FIFO between the misc unit and the UART TX bridge; push is accepted when
// not full or when a pop frees a slot in the same cycle.
module misc_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/misc_exec_unit.sv
// Misc execution element: NOP/HALT/IN/OUT/INW/OUTW with issue/done handshake.
// Optional MISC_CYCLE_COUNTER_EN adds a 64-bit cycle counter read by RDCYC.
//
// state      | meaning
// IDLE       | waiting for issue
// RX         | requesting/collecting RX bytes for IN/INW
// TX_PUSH    | pushing OUT/OUTW bytes, stalling while the FIFO is full
// DRAIN      | HALT issued, waiting for the TX FIFO to empty
// HALTED     | stopped until reset
module misc_exec_unit
  import misc_exec_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int TX_DEPTH   = 8,
  parameter int RX_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue,
  input  logic [5:0]        inst_num,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rd,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out,
  output logic              timeout,
  output logic              halted,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              rx_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_ack
);

  localparam int WORD_BYTES = DATA_W / 8;
  localparam int IW         = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TMR_W      = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam int CNT_W      = $clog2(TX_DEPTH) + 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'((RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic              halted_q, halted_d, rx_req_q, rx_req_d;
  logic [DATA_W-1:0] out_q, out_d, word_q, word_d;
  logic [IW-1:0]     idx_q, idx_d, last_q, last_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic              fifo_push, fifo_full, fifo_empty, tx_pop, push_ok;
  logic [7:0]        fifo_wdata, fifo_head;
  logic [CNT_W-1:0]  tx_count;

`ifdef MISC_CYCLE_COUNTER_EN
  logic [63:0] cyc_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc_q <= '0;
    else          cyc_q <= cyc_q + 64'd1;
  end
`endif

  assign tx_pop  = tx_valid && tx_ready;
  assign push_ok = !fifo_full || tx_pop;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    halted_d   = halted_q;
    rx_req_d   = rx_req_q;
    out_d      = out_q;
    word_d     = word_q;
    idx_d      = idx_q;
    last_d     = last_q;
    tmr_d      = tmr_q;
    fifo_push  = 1'b0;
    fifo_wdata = word_q[8*idx_q +: 8];
    case (state_q)
      ST_IDLE: if (issue) begin
        case (inst_num)
          OP_HALT: begin
            state_d = ST_DRAIN;
            busy_d  = 1'b1;
          end
          OP_IN, OP_INW: begin
            state_d  = ST_RX;
            busy_d   = 1'b1;
            rx_req_d = 1'b1;
            out_d    = rd;
            idx_d    = '0;
            last_d   = (inst_num == OP_INW) ? IW'(WORD_BYTES - 1) : '0;
            tmr_d    = TMR_LOAD;
          end
          OP_OUT: begin
            out_d      = ALL_ONES[DATA_W-1:0];
            word_d     = rs;
            idx_d      = '0;
            last_d     = '0;
            fifo_push  = 1'b1;
            fifo_wdata = rs[7:0];
            if (push_ok) done_d = 1'b1;
            else begin
              state_d = ST_TX_PUSH;
              busy_d  = 1'b1;
            end
          end
          OP_OUTW: begin
            out_d   = ALL_ONES[DATA_W-1:0];
            word_d  = rs;
            idx_d   = '0;
            last_d  = IW'(WORD_BYTES - 1);
            state_d = ST_TX_PUSH;
            busy_d  = 1'b1;
          end
`ifdef MISC_CYCLE_COUNTER_EN
          OP_RDCYC: begin
            out_d  = cyc_q[DATA_W-1:0];
            done_d = 1'b1;
          end
`endif
          default: begin
            out_d  = ALL_ONES[DATA_W-1:0];
            done_d = 1'b1;
          end
        endcase
      end
      ST_RX: begin
        // rx_ack only counts while a request is outstanding
        if (rx_req_q && rx_ack) begin
          out_d[8*idx_q +: 8] = rx_data;
          rx_req_d = 1'b0;
          if (idx_q == last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (!rx_req_q) begin
          rx_req_d = 1'b1;
          tmr_d    = TMR_LOAD;
        end else if (RX_TIMEOUT != 0) begin
          if (tmr_q == '0) begin
            done_d    = 1'b1;
            timeout_d = 1'b1;
            rx_req_d  = 1'b0;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
      end
      ST_TX_PUSH: begin
        fifo_push = 1'b1;
        if (push_ok) begin
          if (idx_q == last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_DRAIN: if (tx_count == '0) begin
        state_d  = ST_HALTED;
        busy_d   = 1'b0;
        halted_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      halted_q  <= 1'b0;
      rx_req_q  <= 1'b0;
      out_q     <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      halted_q  <= halted_d;
      rx_req_q  <= rx_req_d;
      out_q     <= out_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      tmr_q     <= tmr_d;
    end
  end

  misc_tx_fifo #(.W(8), .DEPTH(TX_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .full      (fifo_full),
    .pop       (tx_pop),
    .empty     (fifo_empty),
    .count     (tx_count),
    .head      (fifo_head)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign out      = out_q;
  assign timeout  = timeout_q;
  assign halted   = halted_q;
  assign rx_req   = rx_req_q;
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_head;

endmodule

// File: tb/tb_misc_exec_unit.sv
// Scoreboard bench for misc_exec_unit: stimulus pushes expected results, monitors pop and compare.
module tb_misc_exec_unit;

  localparam int DW = 32;
  localparam logic [DW-1:0] ONES = '1;
  localparam logic [5:0] NOP = 6'd4, HALT = 6'd5, IN = 6'd6, OUT = 6'd7,
                         INW = 6'd8, OUTW = 6'd9, RDCYC = 6'd10;

  logic          clk = 1'b0, reset_n = 1'b0, issue = 1'b0, tx_ready = 1'b0, rx_ack = 1'b0;
  logic [5:0]    inst_num = '0;
  logic [DW-1:0] rs = '0, rd = '0;
  logic [7:0]    rx_data = '0;
  logic          busy, done, timeout, halted, tx_valid, rx_req;
  logic [DW-1:0] out;
  logic [7:0]    tx_data;

  misc_exec_unit #(.DATA_W(DW), .TX_DEPTH(8), .RX_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .issue(issue), .inst_num(inst_num), .rs(rs), .rd(rd),
    .busy(busy), .done(done), .out(out), .timeout(timeout), .halted(halted),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_data(rx_data), .rx_ack(rx_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] val; logic tmo; int due; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  int total = 0, bad = 0, cyc = 0, req_cnt = 0, gap_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [7:0] b;
    if (rx_req) req_cnt <= req_cnt + 1;
    if (busy && !rx_req) gap_cnt <= gap_cnt + 1;
    if (done) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done out=%0h expected no done", out);
      end else begin
        e = exp_q.pop_front();
        chk("done_out", out, e.val);
        chk("done_timeout", timeout, e.tmo);
        if (e.due >= 0) chk("done_latency_cycle", cyc, e.due);
      end
    end
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_tx: got %0h expected no byte", tx_data);
      end else begin
        b = tx_q.pop_front();
        chk("tx_byte", tx_data, b);
      end
    end
  end

  task automatic tick(input int n = 1);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) tick();
    chk("idle_wait", busy, 0);
  endtask

  task automatic do_issue(input logic [5:0] op, input logic [DW-1:0] s, input logic [DW-1:0] d,
                          input logic [DW-1:0] ev, input logic et, input bit lat1, input bit want_done);
    exp_t e;
    wait_idle();
    if (want_done) begin
      e.val = ev; e.tmo = et; e.due = lat1 ? cyc + 1 : -1;
      exp_q.push_back(e);
    end
    inst_num = op; rs = s; rd = d; issue = 1'b1;
    tick();
    issue = 1'b0;
  endtask

  task automatic out_byte(input logic [7:0] b, input bit expect_tx);
    do_issue(OUT, {24'hABCDEF, b}, '0, ONES, 1'b0, 1'b1, 1'b1);
    if (expect_tx) tx_q.push_back(b);
  endtask

  task automatic rx_byte(input logic [7:0] b, input int dly, input bit hold_extra);
    for (int i = 0; i < 100 && !rx_req; i++) tick();
    chk("rx_req_wait", rx_req, 1);
    tick(dly);
    rx_data = b; rx_ack = 1'b1;
    tick();
    if (hold_extra) begin
      rx_data = 8'h55;
      tick();
    end
    rx_ack = 1'b0; rx_data = '0;
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    for (int i = 0; i < 200 && (tx_valid || busy); i++) tick();
    chk("drain_empty", tx_valid, 0);
    tx_ready = 1'b0;
  endtask

  initial begin
    int snap_req, snap_gap;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    chk("rst_flags", {timeout, halted, tx_valid, rx_req}, 0);
    chk("rst_tx_data", tx_data, 0);
    reset_n = 1'b1;
    tick(2);

    // NOP and illegal opcodes retire at latency 1 with all ones
    do_issue(NOP, 32'h1, 32'h2, ONES, 1'b0, 1'b1, 1'b1);
    do_issue(6'd0, '0, '0, ONES, 1'b0, 1'b1, 1'b1);
    do_issue(6'd63, '0, '0, ONES, 1'b0, 1'b1, 1'b1);
    do_issue(6'd11, '0, '0, ONES, 1'b0, 1'b1, 1'b1);
`ifndef MISC_CYCLE_COUNTER_EN
    do_issue(RDCYC, '0, '0, ONES, 1'b0, 1'b1, 1'b1);
`endif

    // OUT 0x41, 0x42 queued while UART stalled, then released in order
    out_byte(8'h41, 1'b1);
    out_byte(8'h42, 1'b1);
    tick(2);
    chk("out_head_valid", tx_valid, 1);
    chk("out_head_data", tx_data, 8'h41);
    drain();

    // OUTW after 6 queued bytes: stalls on full, finishes after release
    for (int i = 1; i <= 6; i++) out_byte(8'(i), 1'b1);
    do_issue(OUTW, 32'h44332211, '0, ONES, 1'b0, 1'b0, 1'b1);
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33); tx_q.push_back(8'h44);
    tick(6);
    chk("outw_stalled_busy", busy, 1);
    chk("outw_stalled_head", tx_data, 8'h01);
    drain();

    // OUT into a full FIFO waits in TX_PUSH
    for (int i = 0; i < 8; i++) out_byte(8'h80 + 8'(i), 1'b1);
    do_issue(OUT, 32'h88, '0, ONES, 1'b0, 1'b0, 1'b1);
    tx_q.push_back(8'h88);
    tick(3);
    chk("out_full_busy", busy, 1);
    drain();

    // Stray rx_ack while idle is ignored (monitor flags any done)
    rx_ack = 1'b1; rx_data = 8'h77;
    tick();
    rx_ack = 1'b0; rx_data = '0;
    tick(2);

    // INW little endian; one extra ack during the gap must be ignored
    snap_gap = gap_cnt;
    do_issue(INW, '0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    rx_byte(8'hEF, 3, 1'b0);
    rx_byte(8'hBE, 3, 1'b1);
    rx_byte(8'hAD, 3, 1'b0);
    rx_byte(8'hDE, 3, 1'b0);
    wait_idle();
    tick(2);
    chk("inw_req_gaps", gap_cnt - snap_gap, 3);

    // IN with no response times out after 16 request cycles
    snap_req = req_cnt;
    do_issue(IN, '0, 32'h12345600, 32'h12345600, 1'b1, 1'b0, 1'b1);
    wait_idle();
    tick(2);
    chk("in_timeout_wait", req_cnt - snap_req, 16);
    chk("in_timeout_req_low", rx_req, 0);

    // INW timing out after two bytes keeps the merged bytes over rd
    do_issue(INW, '0, 32'h11223344, 32'h1122BBAA, 1'b1, 1'b0, 1'b1);
    rx_byte(8'hAA, 1, 1'b0);
    rx_byte(8'hBB, 1, 1'b0);
    wait_idle();
    tick(2);

    // Reset in the middle of an INW with bytes sitting in the FIFO
    out_byte(8'h71, 1'b0);
    out_byte(8'h72, 1'b0);
    do_issue(INW, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    rx_byte(8'h01, 1, 1'b0);
    rx_byte(8'h02, 1, 1'b0);
    tick();
    #3 reset_n = 1'b0;
    #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_rx_req", rx_req, 0);
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_done", done, 0);
    tick();
    reset_n = 1'b1;
    tick(4);
    chk("post_rst_fifo_empty", tx_valid, 0);
    do_issue(IN, '0, 32'h12345678, 32'h1234569A, 1'b0, 1'b0, 1'b1);
    rx_byte(8'h9A, 2, 1'b0);
    wait_idle();
    tick(2);

    // HALT drains three queued bytes, then ignores further issues
    out_byte(8'h61, 1'b1);
    out_byte(8'h62, 1'b1);
    out_byte(8'h63, 1'b1);
    do_issue(HALT, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk("halt_draining_busy", busy, 1);
    chk("halt_not_yet", halted, 0);
    tx_ready = 1'b1;
    for (int i = 0; i < 100 && !halted; i++) tick();
    chk("halted_set", halted, 1);
    chk("halt_all_popped", tx_q.size(), 0);
    chk("halt_tx_idle", tx_valid, 0);
    do_issue(NOP, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick(5);
    chk("halted_sticky", halted, 1);
    chk("halted_not_busy", busy, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("tx_queue_empty", tx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
